// File: rtl/kanagawa_fifo_arb_pkg.sv
// Shared types and helpers for the Kanagawa FIFO write arbiter.
package kanagawa_fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int credits_w(input int depth, input int af);
    return $clog2(depth - af + 1);
  endfunction

endpackage

// File: rtl/kanagawa_rr_picker.sv
// Round-robin picker: first set bit of valid at or after ptr, wrapping around.
module kanagawa_rr_picker #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] N_V = (IW + 1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;
  logic [IW:0]    w_wrap;

  // Rotating a doubled copy puts ptr at bit 0 without any modulo arithmetic.
  assign w_dbl = {valid, valid} >> ptr;
  assign w_rot = w_dbl[N-1:0];

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    found = 1'b0;
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        found = 1'b1;
        w_off = IW'(k);
      end
    end
  end

  assign w_sum  = {1'b0, ptr} + {1'b0, w_off};
  assign w_wrap = w_sum - N_V;
  assign idx    = (w_sum >= N_V) ? w_wrap[IW-1:0] : w_sum[IW-1:0];

endmodule

// File: rtl/kanagawa_fifo_write_arbiter.sv
// Round-robin, packet-locking, credit-flow-controlled arbiter that shares one
// write port of a KanagawaWriteDelayFifo between NUM_REQ producers.
module kanagawa_fifo_write_arbiter
  import kanagawa_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ            = 3,
  parameter  int WIDTH              = 32,
  parameter  int DEPTH              = 16,
  parameter  int ALMOSTFULL_ENTRIES = 2,
  localparam int IDX_W              = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CRED_W             = credits_w(DEPTH, ALMOSTFULL_ENTRIES)
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_wrreq,
  output logic [WIDTH-1:0]         fifo_data,
  input  logic                     fifo_full,
  input  logic                     fifo_rdreq,
  input  logic                     fifo_empty,
  output logic [IDX_W-1:0]         grant_id,
  output logic [CRED_W-1:0]        credits,
  output logic                     credit_err
);

  localparam int                CREDITS  = DEPTH - ALMOSTFULL_ENTRIES;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_grant_id;
  logic [IDX_W-1:0]   w_sel, w_pick_idx;
  logic               w_pick_found, w_gate, w_xfer, w_last, w_pop;
  logic [CRED_W-1:0]  r_credits;
  logic               r_wrreq, r_credit_err;
  logic [WIDTH-1:0]   r_data, w_sel_data;

  kanagawa_rr_picker #(.N(NUM_REQ)) u_picker (
    .valid (req_valid),
    .ptr   (r_rr_ptr),
    .found (w_pick_found),
    .idx   (w_pick_idx)
  );

  // Registered credits only: a credit returning this cycle opens the gate next cycle.
  assign w_gate = rst && (r_credits != '0) && !fifo_full;
  assign w_pop  = fifo_rdreq && !fifo_empty;

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
    w_sel        = r_owner;
    req_ready    = '0;
    w_xfer       = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_sel = w_pick_idx;
        if (w_pick_found && w_gate) req_ready[w_pick_idx] = 1'b1;
      end
      LOCKED: begin
        if (w_gate) req_ready[r_owner] = 1'b1;
      end
      default: ;
    endcase
    w_xfer = |(req_valid & req_ready);
    w_last = req_last[w_sel];
    if (w_xfer) begin
      if (w_last) begin
        w_state_nxt  = IDLE;
        w_rr_ptr_nxt = (w_sel == LAST_IDX) ? '0 : w_sel + IDX_W'(1);
      end else begin
        w_state_nxt = LOCKED;
        w_owner_nxt = w_sel;
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == IDX_W'(i)) w_sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      r_wrreq      <= 1'b0;
      r_data       <= '0;
      r_grant_id   <= '0;
      r_credits    <= CRED_MAX;
      r_credit_err <= 1'b0;
    end else begin
      r_wrreq <= w_xfer;
      if (w_xfer) begin
        r_data     <= w_sel_data;
        r_grant_id <= w_sel;
      end
      // Credit is taken at grant, ahead of the FIFO's write-delay pipeline.
      if (w_xfer && !w_pop) begin
        r_credits <= r_credits - CRED_W'(1);
      end else if (!w_xfer && w_pop) begin
        if (r_credits == CRED_MAX) r_credit_err <= 1'b1;
        else                       r_credits    <= r_credits + CRED_W'(1);
      end
    end
  end

  assign fifo_wrreq = r_wrreq;
  assign fifo_data  = r_data;
  assign grant_id   = r_grant_id;
  assign credits    = r_credits;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_kanagawa_fifo_write_arbiter.sv
// Directed and randomized bench for kanagawa_fifo_write_arbiter with a
// behavioural arbiter model and a write-delay FIFO model.
module tb_kanagawa_fifo_write_arbiter;

  localparam int N       = 3;
  localparam int W       = 32;
  localparam int DEPTH   = 16;
  localparam int AF      = 2;
  localparam int CREDITS = DEPTH - AF;
  localparam int CW      = $clog2(CREDITS + 1);
  localparam int WD      = 2;

  logic          clock = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic          fifo_wrreq;
  logic [W-1:0]  fifo_data;
  logic          fifo_full, fifo_rdreq, fifo_empty;
  logic [1:0]    grant_id;
  logic [CW-1:0] credits;
  logic          credit_err;

  always #5 clock = ~clock;

  kanagawa_fifo_write_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .DEPTH(DEPTH), .ALMOSTFULL_ENTRIES(AF)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wrreq (fifo_wrreq),
    .fifo_data  (fifo_data),
    .fifo_full  (fifo_full),
    .fifo_rdreq (fifo_rdreq),
    .fifo_empty (fifo_empty),
    .grant_id   (grant_id),
    .credits    (credits),
    .credit_err (credit_err)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference arbiter state.
  int          m_cred   = CREDITS;
  bit          m_locked = 1'b0;
  int          m_owner  = 0;
  int          m_rr     = 0;
  int          m_grant  = 0;
  bit          m_wr     = 1'b0;
  bit          m_err    = 1'b0;
  logic [W-1:0] m_data  = '0;

  // FIFO model: visible count plus a write-delay pipeline.
  int f_cnt = 0;
  int f_pipe[WD];
  bit force_full     = 1'b0;
  bit force_nonempty = 1'b0;
  int wr_count       = 0;
  int wr_ids[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_ready;
    int sel;
    bit xfer, pop, wr_now;
    fifo_empty = !force_nonempty && (f_cnt == 0);
    fifo_full  = force_full || (f_cnt >= CREDITS);
    #1;
    exp_ready = '0;
    sel = -1;
    if (rst && m_cred > 0 && !fifo_full) begin
      if (m_locked) sel = m_owner;
      else begin
        for (int k = 0; k < N; k++) begin
          if (req_valid[(m_rr + k) % N]) begin
            sel = (m_rr + k) % N;
            break;
          end
        end
      end
      if (sel >= 0) exp_ready[sel] = 1'b1;
    end
    xfer = (sel >= 0) && req_valid[sel];
    pop  = fifo_rdreq && !fifo_empty;
    check("ready", req_ready, exp_ready);
    check("ready_onehot0", $onehot0(req_ready), 1);
    wr_now = (fifo_wrreq === 1'b1);
    if (wr_now) check("wr_room", (f_cnt + f_pipe[0] + f_pipe[1]) < DEPTH, 1);
    @(posedge clock);
    if (!rst) begin
      f_cnt = 0;
      for (int i = 0; i < WD; i++) f_pipe[i] = 0;
    end else begin
      if (fifo_rdreq && f_cnt > 0) f_cnt--;
      f_cnt += f_pipe[WD-1];
      for (int i = WD - 1; i > 0; i--) f_pipe[i] = f_pipe[i-1];
      f_pipe[0] = wr_now ? 1 : 0;
    end
    if (!rst) begin
      m_cred = CREDITS; m_locked = 0; m_owner = 0; m_rr = 0;
      m_grant = 0; m_wr = 0; m_data = '0; m_err = 0;
    end else begin
      m_wr = xfer;
      if (xfer) begin
        m_data  = req_data[sel*W +: W];
        m_grant = sel;
        if (req_last[sel]) begin
          m_locked = 0;
          m_rr     = (sel + 1) % N;
        end else begin
          m_locked = 1;
          m_owner  = sel;
        end
      end
      m_cred = m_cred - (xfer ? 1 : 0) + (pop ? 1 : 0);
      if (m_cred > CREDITS) begin
        m_cred = CREDITS;
        m_err  = 1'b1;
      end
    end
    #1;
    check("fifo_wrreq", fifo_wrreq, m_wr);
    check("fifo_data", fifo_data, m_data);
    check("grant_id", grant_id, m_grant);
    check("credits", credits, m_cred);
    check("credit_err", credit_err, m_err);
    if (fifo_wrreq === 1'b1) begin
      wr_count++;
      wr_ids.push_back(int'(grant_id));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; req_last = '0; fifo_rdreq = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < WD; i++) f_pipe[i] = 0;
    req_data = '0;
    do_reset();
    check("rst_credits", credits, CREDITS);
    check("rst_wrreq", fifo_wrreq, 0);

    // 1: all producers single-beat, no pops: 14 writes in rotation, then stall.
    wr_count = 0; wr_ids.delete();
    req_valid = '1; req_last = '1;
    for (int c = 0; c < 16; c++) begin
      req_data = {$urandom(), $urandom(), $urandom()};
      step();
    end
    check("t1_writes", wr_count, 14);
    check("t1_credits0", credits, 0);
    check("t1_ready_idle", req_ready, 0);
    for (int k = 0; k < 14; k++) check("t1_rotation", wr_ids[k], k % 3);

    // 2: a single pop from empty credits allows exactly one more write.
    fifo_rdreq = 1'b1;
    step();
    check("t2_credit1", credits, 1);
    fifo_rdreq = 1'b0; wr_count = 0;
    for (int c = 0; c < 4; c++) step();
    check("t2_one_write", wr_count, 1);
    check("t2_credits0", credits, 0);

    // 3: 4-beat packet from req0 with a bubble; others stay valid.
    do_reset();
    wr_ids.delete();
    req_last = 3'b110;
    req_data = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    req_valid = 3'b111; step();
    req_data[W-1:0] = 32'h0000_0001; step();
    req_valid = 3'b110; step();
    req_valid = 3'b111; req_data[W-1:0] = 32'h0000_0002; step();
    req_last = 3'b111;  req_data[W-1:0] = 32'h0000_0003; step();
    req_valid = 3'b110; step();
    check("t3_write_count", wr_ids.size(), 5);
    for (int k = 0; k < 5; k++) check("t3_owner_seq", wr_ids[k], (k < 4) ? 0 : 1);

    // 4: steady state at credits=5 with transfer and pop each cycle.
    do_reset();
    req_valid = 3'b001; req_last = 3'b111;
    for (int c = 0; c < 9; c++) begin req_data = {3{$urandom()}}; step(); end
    req_valid = '0;
    for (int c = 0; c < 3; c++) step();
    check("t4_credits5", credits, 5);
    req_valid = 3'b001; fifo_rdreq = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_data = {3{$urandom()}};
      step();
      check("t4_hold5", credits, 5);
      check("t4_wr_each", fifo_wrreq, 1);
    end
    fifo_rdreq = 1'b0; req_valid = '0;

    // 5: reset mid-packet (owner 2, credits 9, rr_ptr 1) aborts the lock.
    do_reset();
    req_valid = 3'b001; req_last = 3'b111;
    for (int c = 0; c < 4; c++) step();
    req_valid = 3'b100; req_last = 3'b000; req_data = {3{32'hCAFE_0002}};
    step();
    check("t5_credits9", credits, 9);
    rst = 1'b0; req_valid = 3'b111; req_last = 3'b111;
    step();
    check("t5_rst_credits", credits, CREDITS);
    check("t5_rst_wrreq", fifo_wrreq, 0);
    rst = 1'b1;
    step();
    check("t5_grant_rr0", grant_id, 0);
    check("t5_wr_after", fifo_wrreq, 1);

    // 6: pop at full credits saturates and sets the sticky error.
    do_reset();
    fifo_rdreq = 1'b1; force_nonempty = 1'b1;
    step();
    check("t6_saturate", credits, CREDITS);
    check("t6_err_set", credit_err, 1);
    fifo_rdreq = 1'b0; force_nonempty = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("t6_err_sticky", credit_err, 1);
    do_reset();
    check("t6_err_clear", credit_err, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 99) != 0);
      req_valid  = N'($urandom_range(0, 7));
      req_last   = N'($urandom_range(0, 7));
      req_data   = {$urandom(), $urandom(), $urandom()};
      fifo_rdreq = (c < 300) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      force_full = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
